// File: rtl/uart_pkg.sv
// Shared UART definitions: default frame/baud parameters and the receiver state type.
// Imported by the rx unit, the baud generator and the tx unit.
package uart_pkg;

  localparam int unsigned UartDataBits   = 8;
  localparam int unsigned UartStopBits   = 1;
  localparam int unsigned UartOvrsampling = 16;
  localparam int unsigned UartDvsrWidth  = 11;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Baud tick generator: emits a one-clock s_tick every dvsr+1 clocks.
// Ports:
//   clk    - system clock
//   reset  - asynchronous, active-low reset
//   dvsr   - tick period minus one
//   s_tick - one-clock tick pulse
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned DVSR_WIDTH = UartDvsrWidth
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DVSR_WIDTH-1:0] dvsr,
  output logic                  s_tick
);

  logic [DVSR_WIDTH-1:0] cnt_q, cnt_d;

  // >= rather than == so that lowering dvsr while cnt is above it ticks at once
  // instead of wrapping through the whole counter range.
  always_comb begin
    s_tick = (cnt_q >= dvsr);
    cnt_d  = s_tick ? '0 : cnt_q + DVSR_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_unit.sv
// Oversampling UART receiver with its own baud tick generator.
// Recovers start/data/stop frames from rx and reports each byte with a one-clock done pulse
// and a framing-error flag. A line held low past the stop bit is treated as a break and
// reported once.
// Ports:
//   clk          - system clock
//   reset        - asynchronous, active-low reset
//   dvsr         - baud tick period minus one
//   rx           - asynchronous serial input, idle high
//   dout         - last received byte (held between pulses)
//   rx_done_tick - one-clock pulse when dout/frame_err are updated
//   frame_err    - a stop-bit sample of the last frame was low
//   busy         - receiver is not idle
module uart_rx_unit
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS   = UartDataBits,
  parameter int unsigned STOP_BITS   = UartStopBits,
  parameter int unsigned OVRSAMPLING = UartOvrsampling,
  parameter int unsigned DVSR_WIDTH  = UartDvsrWidth
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DVSR_WIDTH-1:0] dvsr,
  input  logic                  rx,
  output logic [DATA_BITS-1:0]  dout,
  output logic                  rx_done_tick,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int unsigned TW = $clog2(OVRSAMPLING);
  // Bit counter serves both data bits and stop bits; DATA_BITS >= 5 covers STOP_BITS <= 2.
  localparam int unsigned NW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] THalf     = TW'(OVRSAMPLING / 2 - 1);
  localparam logic [TW-1:0] TLast     = TW'(OVRSAMPLING - 1);
  localparam logic [NW-1:0] NLastData = NW'(DATA_BITS - 1);
  localparam logic [NW-1:0] NLastStop = NW'(STOP_BITS - 1);

  logic s_tick;

  uart_baud_gen #(
    .DVSR_WIDTH(DVSR_WIDTH)
  ) u_baud_gen (
    .clk   (clk),
    .reset (reset),
    .dvsr  (dvsr),
    .s_tick(s_tick)
  );

  uart_rx_state_t         state_q, state_d;
  logic [1:0]             sync_q, sync_d;
  logic [TW-1:0]          t_q, t_d;
  logic [NW-1:0]          n_q, n_d;
  logic [DATA_BITS-1:0]   sh_q, sh_d;
  logic                   err_q, err_d;
  logic [DATA_BITS-1:0]   dout_q, dout_d;
  logic                   frame_err_q, frame_err_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic                   rx_s;

  assign rx_s = sync_q[1];

  always_comb begin
    sync_d      = {sync_q[0], rx};
    state_d     = state_q;
    t_d         = t_q;
    n_d         = n_q;
    sh_d        = sh_q;
    err_d       = err_q;
    dout_d      = dout_q;
    frame_err_d = frame_err_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Edge detection does not wait for a tick; sample points are timed from here.
        if (!rx_s) begin
          state_d = START;
          t_d     = '0;
          err_d   = 1'b0;
        end
      end
      START: begin
        if (s_tick) begin
          if (t_q == THalf) begin
            if (!rx_s) begin
              state_d = DATA;
              t_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE; // line back high at mid start bit: glitch
            end
          end else begin
            t_d = t_q + TW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (t_q == TLast) begin
            sh_d = {rx_s, sh_q[DATA_BITS-1:1]};
            t_d  = '0;
            if (n_q == NLastData) begin
              state_d = STOP;
              n_d     = '0;
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            t_d = t_q + TW'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (t_q == TLast) begin
            t_d = '0;
            if (!rx_s) begin
              err_d = 1'b1;
            end
            if (n_q == NLastStop) begin
              dout_d      = sh_q;
              frame_err_d = err_q | ~rx_s;
              done_d      = 1'b1;
              state_d     = rx_s ? IDLE : BREAK;
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            t_d = t_q + TW'(1);
          end
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sync_q      <= 2'b11;
      t_q         <= '0;
      n_q         <= '0;
      sh_q        <= '0;
      err_q       <= 1'b0;
      dout_q      <= '0;
      frame_err_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      t_q         <= t_d;
      n_q         <= n_d;
      sh_q        <= sh_d;
      err_q       <= err_d;
      dout_q      <= dout_d;
      frame_err_q <= frame_err_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = frame_err_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_uart_rx_unit.sv
// Directed bench for uart_rx_unit. Expected {frame_err, byte} pairs are queued as frames are
// driven and compared when the receiver pulses rx_done_tick. A second instance covers
// two stop bits at dvsr=0.
module tb_uart_rx_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [10:0] dvsr1, dvsr2;
  logic       rx1, rx2;
  logic [7:0] dout1, dout2;
  logic       done1, done2, ferr1, ferr2, busy1, busy2;

  int unsigned total  = 0;
  int unsigned passed = 0;
  int unsigned cyc    = 0;
  int unsigned done1_cnt = 0;
  int unsigned last_done2_cyc = 0;

  logic [8:0] exp1_q[$];
  logic [8:0] exp2_q[$];
  logic [8:0] e1, e2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  uart_rx_unit u_dut1 (
    .clk         (clk),
    .reset       (reset),
    .dvsr        (dvsr1),
    .rx          (rx1),
    .dout        (dout1),
    .rx_done_tick(done1),
    .frame_err   (ferr1),
    .busy        (busy1)
  );

  uart_rx_unit #(
    .STOP_BITS(2)
  ) u_dut2 (
    .clk         (clk),
    .reset       (reset),
    .dvsr        (dvsr2),
    .rx          (rx2),
    .dout        (dout2),
    .rx_done_tick(done2),
    .frame_err   (ferr2),
    .busy        (busy2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (reset && done1) begin
      done1_cnt++;
      if (exp1_q.size() == 0) begin
        check("dut1_spurious_done", {31'd0, done1}, 32'd0);
      end else begin
        e1 = exp1_q.pop_front();
        check("dut1_dout", {24'd0, dout1}, {24'd0, e1[7:0]});
        check("dut1_frame_err", {31'd0, ferr1}, {31'd0, e1[8]});
      end
    end
    if (reset && done2) begin
      last_done2_cyc = cyc;
      if (exp2_q.size() == 0) begin
        check("dut2_spurious_done", {31'd0, done2}, 32'd0);
      end else begin
        e2 = exp2_q.pop_front();
        check("dut2_dout", {24'd0, dout2}, {24'd0, e2[7:0]});
        check("dut2_frame_err", {31'd0, ferr2}, {31'd0, e2[8]});
      end
    end
  end

  task automatic drive(input int which, input logic v);
    if (which == 1) rx1 = v;
    else rx2 = v;
  endtask

  // Drives one frame; the caller is at a negedge and queues the expected result.
  task automatic send(input int which, input logic [7:0] data, input logic stop_lvl,
                      input int nstop, input int bit_clks, input bit chk_busy);
    drive(which, 1'b0);
    repeat (bit_clks) @(negedge clk);
    if (chk_busy) check("busy_in_frame", {31'd0, busy1}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      drive(which, data[i]);
      repeat (bit_clks) @(negedge clk);
    end
    for (int s = 0; s < nstop; s++) begin
      drive(which, stop_lvl);
      repeat (bit_clks) @(negedge clk);
    end
  endtask

  task automatic wait_drain(input int which, input int budget, input string tag);
    int n = 0;
    while (((which == 1) ? exp1_q.size() : exp2_q.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, (which == 1) ? exp1_q.size() : exp2_q.size(), 32'd0);
  endtask

  initial begin
    int unsigned t0;
    int unsigned lat;

    reset = 1'b0;
    rx1   = 1'b1;
    rx2   = 1'b1;
    dvsr1 = 11'd3;
    dvsr2 = 11'd0;
    repeat (3) @(negedge clk);
    check("rst_dout", {24'd0, dout1}, 32'd0);
    check("rst_done", {31'd0, done1}, 32'd0);
    check("rst_ferr", {31'd0, ferr1}, 32'd0);
    check("rst_busy", {31'd0, busy1}, 32'd0);
    reset = 1'b1;
    repeat (10) @(negedge clk);

    // 1: single frame
    exp1_q.push_back({1'b0, 8'hA5});
    send(1, 8'hA5, 1'b1, 1, 64, 1'b1);
    repeat (40) @(negedge clk);
    wait_drain(1, 200, "t1_drain");
    check("t1_busy_low", {31'd0, busy1}, 32'd0);
    check("t1_pulses", done1_cnt, 32'd1);

    // 2: back-to-back frames
    exp1_q.push_back({1'b0, 8'h00});
    exp1_q.push_back({1'b0, 8'hFF});
    exp1_q.push_back({1'b0, 8'h3C});
    send(1, 8'h00, 1'b1, 1, 64, 1'b0);
    send(1, 8'hFF, 1'b1, 1, 64, 1'b0);
    send(1, 8'h3C, 1'b1, 1, 64, 1'b0);
    wait_drain(1, 200, "t2_drain");
    check("t2_pulses", done1_cnt, 32'd4);

    // 3: short low glitch is rejected at mid start bit
    rx1 = 1'b0;
    repeat (20) @(negedge clk);
    check("t3_busy_start", {31'd0, busy1}, 32'd1);
    rx1 = 1'b1;
    repeat (100) @(negedge clk);
    check("t3_busy_idle", {31'd0, busy1}, 32'd0);
    check("t3_pulses", done1_cnt, 32'd4);

    // 4: low stop bit followed by a long break, then a clean frame
    exp1_q.push_back({1'b1, 8'h55});
    send(1, 8'h55, 1'b0, 1, 64, 1'b0);
    repeat (2000) @(negedge clk);
    check("t4_break_busy", {31'd0, busy1}, 32'd1);
    check("t4_pulses", done1_cnt, 32'd5);
    rx1 = 1'b1;
    repeat (10) @(negedge clk);
    check("t4_idle", {31'd0, busy1}, 32'd0);
    exp1_q.push_back({1'b0, 8'h12});
    send(1, 8'h12, 1'b1, 1, 64, 1'b0);
    wait_drain(1, 200, "t4_drain");
    check("t4_pulses2", done1_cnt, 32'd6);

    // 5: reset in the middle of the data bits of 0xC3
    rx1 = 1'b0;
    repeat (64) @(negedge clk);
    rx1 = 1'b1;
    repeat (64) @(negedge clk);
    rx1 = 1'b1;
    repeat (64) @(negedge clk);
    rx1 = 1'b0;
    repeat (30) @(negedge clk);
    reset = 1'b0;
    #1;
    check("t5_dout", {24'd0, dout1}, 32'd0);
    check("t5_done", {31'd0, done1}, 32'd0);
    check("t5_ferr", {31'd0, ferr1}, 32'd0);
    check("t5_busy", {31'd0, busy1}, 32'd0);
    repeat (5) @(negedge clk);
    rx1   = 1'b1;
    reset = 1'b1;
    repeat (20) @(negedge clk);
    exp1_q.push_back({1'b0, 8'h7E});
    send(1, 8'h7E, 1'b1, 1, 64, 1'b0);
    wait_drain(1, 200, "t5_drain");
    check("t5_pulses", done1_cnt, 32'd7);

    // 6a: dvsr=0 with two stop bits; 16*(1+8+2)=176 ticks nominal, +/- one bit
    t0 = cyc;
    exp2_q.push_back({1'b0, 8'h81});
    send(2, 8'h81, 1'b1, 2, 16, 1'b0);
    wait_drain(2, 200, "t6_drain2");
    lat = last_done2_cyc - t0;
    check("t6_latency_in_window", {31'd0, (lat >= 160 && lat <= 192)}, 32'd1);

    // 6b: dvsr drops 650 -> 3 while the line is low; all-zero frame ends in a break
    dvsr1 = 11'd650;
    rx1   = 1'b0;
    exp1_q.push_back({1'b1, 8'h00});
    repeat (3000) @(negedge clk);
    dvsr1 = 11'd3;
    repeat (768) @(negedge clk);
    wait_drain(1, 200, "t6_drain_break");
    rx1 = 1'b1;
    repeat (20) @(negedge clk);
    check("t6_idle", {31'd0, busy1}, 32'd0);
    exp1_q.push_back({1'b0, 8'hE7});
    send(1, 8'hE7, 1'b1, 1, 64, 1'b0);
    wait_drain(1, 200, "t6_drain_clean");
    check("t6_pulses", done1_cnt, 32'd9);

    repeat (10) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
